// File: rtl/guvm_dmem_pkg.sv
// ---------------------------------------------------------------------------
// guvm_dmem_pkg
// Shared types and constants for the GUVM data-memory responder.
//   store_log_t          : one store-log record {addr, data, be}
//   dmem_state_t         : grant FSM states (IDLE, WAIT)
//   DMEM_MAX_GNT_LATENCY : largest supported request-to-grant latency
//   merge_bytes()        : byte-lane merge used for partial stores
// ---------------------------------------------------------------------------
package guvm_dmem_pkg;

    localparam int DMEM_MAX_GNT_LATENCY = 7;
    localparam int DMEM_CNT_W           = 3;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } store_log_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } dmem_state_t;

    // Replace the bytes of old_word selected by be with those of new_word.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  be);
        logic [31:0] result;
        result = old_word;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                result[8*i +: 8] = new_word[8*i +: 8];
            end else begin
                result[8*i +: 8] = old_word[8*i +: 8];
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/guvm_sync_fifo.sv
// ---------------------------------------------------------------------------
// guvm_sync_fifo
// Single-clock FIFO, parameterized by element type and depth (power of two,
// at least 2). Synchronous active-high reset clears pointers and storage so
// the head reads as zero after reset.
//   clk, rst  : clock, synchronous active-high reset
//   push      : write wr_data this cycle (ignored when full unless popping)
//   wr_data   : element to enqueue
//   pop       : consume the head this cycle (ignored when empty)
//   rd_data   : current head element, held until popped
//   valid     : FIFO not empty
//   full      : FIFO holds DEPTH elements
// ---------------------------------------------------------------------------
module guvm_sync_fifo #(
    parameter type T     = logic [7:0],
    parameter int  DEPTH = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  T     wr_data,
    input  logic pop,
    output T     rd_data,
    output logic valid,
    output logic full
);

    localparam int           AW      = $clog2(DEPTH);
    localparam logic [AW:0]  PTR_ONE = {{AW{1'b0}}, 1'b1};

    T            store_r [DEPTH];
    logic [AW:0] wr_ptr_r;
    logic [AW:0] rd_ptr_r;
    logic        do_push_s;
    logic        do_pop_s;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign valid     = (wr_ptr_r != rd_ptr_r);
    assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                       (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign do_pop_s  = pop && valid;
    // A pop in the same cycle frees the slot, so a push into a full FIFO is kept.
    assign do_push_s = push && (!full || do_pop_s);
    assign rd_data   = store_r[rd_ptr_r[AW-1:0]];

    // Pointer and storage update.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                store_r[i] <= '0;
            end
        end else begin
            if (do_push_s) begin
                store_r[wr_ptr_r[AW-1:0]] <= wr_data;
                wr_ptr_r                  <= wr_ptr_r + PTR_ONE;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
        end
    end

endmodule

// File: rtl/guvm_data_mem_responder.sv
// ---------------------------------------------------------------------------
// guvm_data_mem_responder
// Data-memory slave for the GUVM core bench. Answers core loads/stores from
// an internal word array with a configurable request-to-grant latency, and
// logs every granted store into a FIFO drained by the monitor.
//
// Optional feature macro: GUVM_DMEM_STORE_LOG_EN
//   defined   : store-log FIFO and sticky log_overflow_o are implemented
//   undefined : no FIFO; all log_* outputs are 0 and log_ready_i is ignored
//
// Ports:
//   clk_i, rst_i                  clock, synchronous active-high reset
//   data_req_i / data_gnt_o       request / grant (grant may be same-cycle)
//   data_rvalid_o / data_rdata_o  response one cycle after grant
//   data_we_i, data_be_i          store flag, byte enables
//   data_addr_i, data_wdata_i     byte address, store data
//   pre_we_i, pre_addr_i,
//   pre_wdata_i                   full-word preload port
//   log_valid_o / log_ready_i     store-log head handshake
//   log_addr_o, log_data_o,
//   log_be_o                      store-log head contents
//   log_overflow_o                sticky: a store was dropped, log full
// ---------------------------------------------------------------------------
module guvm_data_mem_responder
    import guvm_dmem_pkg::*;
#(
    parameter int MEM_DEPTH   = 256,
    parameter int GNT_LATENCY = 1,
    parameter int LOG_DEPTH   = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        data_req_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic [31:0] data_rdata_o,
    input  logic        pre_we_i,
    input  logic [31:0] pre_addr_i,
    input  logic [31:0] pre_wdata_i,
    output logic        log_valid_o,
    input  logic        log_ready_i,
    output logic [31:0] log_addr_o,
    output logic [31:0] log_data_o,
    output logic [3:0]  log_be_o,
    output logic        log_overflow_o
);

    localparam int                    IDX_W   = $clog2(MEM_DEPTH);
    localparam logic [DMEM_CNT_W-1:0] CNT_ONE = {{(DMEM_CNT_W-1){1'b0}}, 1'b1};
    localparam logic [DMEM_CNT_W-1:0] CNT_LD  = DMEM_CNT_W'(GNT_LATENCY);

    dmem_state_t           state_r;
    logic [DMEM_CNT_W-1:0] cnt_r;
    logic                  gnt_s;
    logic                  store_gnt_s;
    logic                  load_gnt_s;
    logic [IDX_W-1:0]      core_idx_s;
    logic [IDX_W-1:0]      pre_idx_s;
    logic [31:0]           mem_r [MEM_DEPTH];
    logic                  rvalid_r;
    logic [31:0]           rdata_r;
    logic                  unused_inputs_s;

    // Upper address bits wrap and the byte offset is ignored.
    assign core_idx_s  = data_addr_i[IDX_W+1:2];
    assign pre_idx_s   = pre_addr_i[IDX_W+1:2];
    assign store_gnt_s = gnt_s && data_we_i;
    assign load_gnt_s  = gnt_s && !data_we_i;

    // Ignored address bits and (in the log-less build) log_ready_i.
    assign unused_inputs_s = ^{data_addr_i, pre_addr_i, log_ready_i};

    // Grant decode: same-cycle from IDLE at zero latency, else at count 1 in WAIT.
    always_comb begin
        gnt_s = 1'b0;
        if (rst_i) begin
            gnt_s = 1'b0;
        end else if (GNT_LATENCY == 0) begin
            gnt_s = data_req_i && (state_r == IDLE);
        end else begin
            gnt_s = data_req_i && (state_r == WAIT) && (cnt_r == CNT_ONE);
        end
    end

    // Grant-latency FSM; a dropped request in WAIT abandons it without a grant.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r <= IDLE;
            cnt_r   <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (data_req_i && (GNT_LATENCY != 0)) begin
                        state_r <= WAIT;
                        cnt_r   <= CNT_LD;
                    end else begin
                        state_r <= IDLE;
                        cnt_r   <= '0;
                    end
                end
                WAIT: begin
                    if (!data_req_i || (cnt_r == CNT_ONE)) begin
                        state_r <= IDLE;
                        cnt_r   <= '0;
                    end else begin
                        state_r <= WAIT;
                        cnt_r   <= cnt_r - CNT_ONE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    cnt_r   <= '0;
                end
            endcase
        end
    end

    // Word array; a core store to the same word overrides a same-cycle preload.
    always_ff @(posedge clk_i) begin
        if (pre_we_i && !(store_gnt_s && (pre_idx_s == core_idx_s))) begin
            mem_r[pre_idx_s] <= pre_wdata_i;
        end
        if (store_gnt_s) begin
            mem_r[core_idx_s] <= merge_bytes(mem_r[core_idx_s], data_wdata_i, data_be_i);
        end
    end

    // Response register; loads sample the array before any same-cycle write.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rvalid_r <= 1'b0;
            rdata_r  <= 32'h0000_0000;
        end else begin
            rvalid_r <= gnt_s;
            rdata_r  <= load_gnt_s ? mem_r[core_idx_s] : 32'h0000_0000;
        end
    end

    // A reset arriving just after a grant must hide the already-registered response.
    assign data_gnt_o    = gnt_s;
    assign data_rvalid_o = rvalid_r && !rst_i;
    assign data_rdata_o  = rst_i ? 32'h0000_0000 : rdata_r;

`ifdef GUVM_DMEM_STORE_LOG_EN
    store_log_t log_entry_s;
    store_log_t log_head_s;
    logic       log_fifo_valid_s;
    logic       log_full_s;
    logic       overflow_r;

    assign log_entry_s = '{addr: data_addr_i, data: data_wdata_i, be: data_be_i};

    guvm_sync_fifo #(
        .T     (store_log_t),
        .DEPTH (LOG_DEPTH)
    ) u_store_log (
        .clk     (clk_i),
        .rst     (rst_i),
        .push    (store_gnt_s),
        .wr_data (log_entry_s),
        .pop     (log_ready_i),
        .rd_data (log_head_s),
        .valid   (log_fifo_valid_s),
        .full    (log_full_s)
    );

    // Sticky drop flag: a store hit a full log with no pop to make room.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            overflow_r <= 1'b0;
        end else if (store_gnt_s && log_full_s && !log_ready_i) begin
            overflow_r <= 1'b1;
        end else begin
            overflow_r <= overflow_r;
        end
    end

    assign log_valid_o    = log_fifo_valid_s && !rst_i;
    assign log_addr_o     = rst_i ? 32'h0000_0000 : log_head_s.addr;
    assign log_data_o     = rst_i ? 32'h0000_0000 : log_head_s.data;
    assign log_be_o       = rst_i ? 4'h0 : log_head_s.be;
    assign log_overflow_o = overflow_r && !rst_i;
`else
    assign log_valid_o    = 1'b0;
    assign log_addr_o     = 32'h0000_0000;
    assign log_data_o     = 32'h0000_0000;
    assign log_be_o       = 4'h0;
    assign log_overflow_o = 1'b0;
`endif

endmodule

// File: tb/tb_guvm_data_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_guvm_data_mem_responder
// Self-checking bench: u_dut0 runs with GNT_LATENCY=0, u_dut2 with
// GNT_LATENCY=2. Both share every input except the request line.
// ---------------------------------------------------------------------------
module tb_guvm_data_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, req2, we, pre_we, log_ready;
    logic [3:0]  be;
    logic [31:0] addr, wdata, pre_addr, pre_wdata;

    logic        gnt0, rv0, lv0, ovf0;
    logic [31:0] rdata0, laddr0, ldata0;
    logic [3:0]  lbe0;
    logic        gnt2, rv2, lv2, ovf2;
    logic [31:0] rdata2, laddr2, ldata2;
    logic [3:0]  lbe2;

    int checks = 0;
    int errors = 0;
    int first;

    always #5 clk = ~clk;

    guvm_data_mem_responder #(.MEM_DEPTH(256), .GNT_LATENCY(0), .LOG_DEPTH(8)) u_dut0 (
        .clk_i(clk), .rst_i(rst), .data_req_i(req0), .data_gnt_o(gnt0),
        .data_rvalid_o(rv0), .data_we_i(we), .data_be_i(be), .data_addr_i(addr),
        .data_wdata_i(wdata), .data_rdata_o(rdata0), .pre_we_i(pre_we),
        .pre_addr_i(pre_addr), .pre_wdata_i(pre_wdata), .log_valid_o(lv0),
        .log_ready_i(log_ready), .log_addr_o(laddr0), .log_data_o(ldata0),
        .log_be_o(lbe0), .log_overflow_o(ovf0)
    );

    guvm_data_mem_responder #(.MEM_DEPTH(256), .GNT_LATENCY(2), .LOG_DEPTH(8)) u_dut2 (
        .clk_i(clk), .rst_i(rst), .data_req_i(req2), .data_gnt_o(gnt2),
        .data_rvalid_o(rv2), .data_we_i(we), .data_be_i(be), .data_addr_i(addr),
        .data_wdata_i(wdata), .data_rdata_o(rdata2), .pre_we_i(pre_we),
        .pre_addr_i(pre_addr), .pre_wdata_i(pre_wdata), .log_valid_o(lv2),
        .log_ready_i(log_ready), .log_addr_o(laddr2), .log_data_o(ldata2),
        .log_be_o(lbe2), .log_overflow_o(ovf2)
    );

    typedef struct {
        logic        req;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        pre_we;
        logic [31:0] pre_addr;
        logic [31:0] pre_wdata;
        logic        exp_gnt;
        logic        exp_rv;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic w, input logic [3:0] b,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic pw, input logic [31:0] pa, input logic [31:0] pd,
                       input logic eg, input logic ev, input logic [31:0] er);
        vec_t v;
        v = '{r, w, b, a, d, pw, pa, pd, eg, ev, er};
        vecs.push_back(v);
    endtask

    task automatic idle_inputs();
        req0 = 1'b0; req2 = 1'b0; we = 1'b0; be = 4'h0; addr = 32'h0;
        wdata = 32'h0; pre_we = 1'b0; pre_addr = 32'h0; pre_wdata = 32'h0;
        log_ready = 1'b0;
    endtask

    task automatic to_drive();
        @(posedge clk);
        #1;
    endtask

    // Single core transaction on u_dut0 followed by an idle cycle.
    task automatic dut0_load(input string name, input logic [31:0] a, input logic [31:0] exp);
        to_drive();
        idle_inputs();
        req0 = 1'b1; be = 4'hF; addr = a;
        @(negedge clk);
        chk({name, " gnt"}, 32'(gnt0), 32'd1);
        to_drive();
        idle_inputs();
        @(negedge clk);
        chk({name, " rvalid"}, 32'(rv0), 32'd1);
        chk({name, " rdata"}, rdata0, exp);
    endtask

    task automatic pop_expect(input string name, input logic [31:0] a,
                              input logic [31:0] d, input logic [3:0] b);
        to_drive();
        idle_inputs();
        log_ready = 1'b1;
        @(negedge clk);
        chk({name, " valid"}, 32'(lv0), 32'd1);
        chk({name, " addr"}, laddr0, a);
        chk({name, " data"}, ldata0, d);
        chk({name, " be"}, 32'(lbe0), 32'(b));
    endtask

    // Drive req2/rst per cycle from the patterns; return first cycle with gnt2.
    task automatic measure_gnt2(input logic [9:0] req_pat, input logic [9:0] rst_pat,
                                output int found);
        found = -1;
        for (int c = 0; c < 10; c++) begin
            if (found < 0) begin
                to_drive();
                req2 = req_pat[c];
                rst  = rst_pat[c];
                we = 1'b0; be = 4'hF; addr = 32'h10;
                @(negedge clk);
                if (gnt2) found = c;
            end
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        // ---------------- reset state ----------------
        idle_inputs();
        rst = 1'b1;
        req0 = 1'b1; req2 = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst gnt0", 32'(gnt0), 32'd0);
        chk("rst rvalid0", 32'(rv0), 32'd0);
        chk("rst rdata0", rdata0, 32'h0);
        chk("rst log_valid0", 32'(lv0), 32'd0);
        chk("rst log_addr0", laddr0, 32'h0);
        chk("rst log_data0", ldata0, 32'h0);
        chk("rst log_be0", 32'(lbe0), 32'd0);
        chk("rst overflow0", 32'(ovf0), 32'd0);
        chk("rst gnt2", 32'(gnt2), 32'd0);
        to_drive();
        rst = 1'b0;
        idle_inputs();
        @(negedge clk);
        chk("post-rst rvalid0", 32'(rv0), 32'd0);
        chk("post-rst rvalid2", 32'(rv2), 32'd0);

        // ---------------- table: latency-0 traffic ----------------
        //  req we be     addr        wdata         pre pre_addr pre_wdata     gnt rv  rdata
        add(0, 0, 4'h0, 32'h0,      32'h0,        1, 32'h10, 32'hDEADBEEF, 0, 0, 32'h0);
        add(0, 0, 4'h0, 32'h0,      32'h0,        1, 32'h20, 32'h11223344, 0, 0, 32'h0);
        add(0, 0, 4'h0, 32'h0,      32'h0,        1, 32'h24, 32'h55667788, 0, 0, 32'h0);
        add(0, 0, 4'h0, 32'h0,      32'h0,        1, 32'h28, 32'h99AABBCC, 0, 0, 32'h0);
        add(1, 0, 4'hF, 32'h10,     32'h0,        0, 32'h0,  32'h0,        1, 0, 32'h0);
        add(1, 0, 4'hF, 32'h20,     32'h0,        0, 32'h0,  32'h0,        1, 1, 32'hDEADBEEF);
        add(1, 0, 4'hF, 32'h24,     32'h0,        0, 32'h0,  32'h0,        1, 1, 32'h11223344);
        add(1, 0, 4'hF, 32'h28,     32'h0,        0, 32'h0,  32'h0,        1, 1, 32'h55667788);
        add(0, 0, 4'h0, 32'h0,      32'h0,        0, 32'h0,  32'h0,        0, 1, 32'h99AABBCC);
        add(1, 1, 4'h5, 32'h20,     32'hAABBCCDD, 0, 32'h0,  32'h0,        1, 0, 32'h0);
        add(1, 0, 4'hF, 32'h20,     32'h0,        0, 32'h0,  32'h0,        1, 1, 32'h0);
        add(0, 0, 4'h0, 32'h0,      32'h0,        0, 32'h0,  32'h0,        0, 1, 32'h11BB33DD);
        add(1, 1, 4'hF, 32'h24,     32'h12345678, 1, 32'h24, 32'hFFFFFFFF, 1, 0, 32'h0);
        add(1, 1, 4'h8, 32'h42B,    32'h77000000, 1, 32'h30, 32'hCAFEF00D, 1, 1, 32'h0);
        add(1, 0, 4'hF, 32'h24,     32'h0,        0, 32'h0,  32'h0,        1, 1, 32'h0);
        add(1, 0, 4'hF, 32'h28,     32'h0,        0, 32'h0,  32'h0,        1, 1, 32'h12345678);
        add(1, 0, 4'hF, 32'h30,     32'h0,        0, 32'h0,  32'h0,        1, 1, 32'h77AABBCC);
        add(1, 0, 4'hF, 32'h412,    32'h0,        0, 32'h0,  32'h0,        1, 1, 32'hCAFEF00D);
        add(0, 0, 4'h0, 32'h0,      32'h0,        0, 32'h0,  32'h0,        0, 1, 32'hDEADBEEF);

        foreach (vecs[i]) begin
            to_drive();
            req0 = vecs[i].req; req2 = 1'b0; we = vecs[i].we; be = vecs[i].be;
            addr = vecs[i].addr; wdata = vecs[i].wdata; pre_we = vecs[i].pre_we;
            pre_addr = vecs[i].pre_addr; pre_wdata = vecs[i].pre_wdata; log_ready = 1'b0;
            @(negedge clk);
            chk($sformatf("vec%0d gnt", i), 32'(gnt0), 32'(vecs[i].exp_gnt));
            chk($sformatf("vec%0d rvalid", i), 32'(rv0), 32'(vecs[i].exp_rv));
            if (vecs[i].exp_rv) begin
                chk($sformatf("vec%0d rdata", i), rdata0, vecs[i].exp_rdata);
            end
        end

        // ---------------- store log contents and hold ----------------
        to_drive();
        idle_inputs();
        @(negedge clk);
`ifdef GUVM_DMEM_STORE_LOG_EN
        chk("log head valid", 32'(lv0), 32'd1);
        chk("log head addr", laddr0, 32'h20);
        to_drive();
        @(negedge clk);
        chk("log hold addr", laddr0, 32'h20);
        pop_expect("log e0", 32'h20, 32'hAABBCCDD, 4'h5);
        pop_expect("log e1", 32'h24, 32'h12345678, 4'hF);
        pop_expect("log e2", 32'h42B, 32'h77000000, 4'h8);
        to_drive();
        idle_inputs();
        @(negedge clk);
        chk("log drained valid", 32'(lv0), 32'd0);
`else
        chk("nolog valid", 32'(lv0), 32'd0);
        chk("nolog addr", laddr0, 32'h0);
`endif

        // ---------------- latency-2 grant timing on u_dut2 ----------------
        measure_gnt2(10'h3FF, 10'h000, first);
        chk("lat2 gnt cycle", 32'(first), 32'd2);
        to_drive();
        idle_inputs(); rst = 1'b0;
        @(negedge clk);
        chk("lat2 rvalid", 32'(rv2), 32'd1);
        chk("lat2 rdata", rdata2, 32'hDEADBEEF);
        to_drive();
        @(negedge clk);
        chk("lat2 single rvalid", 32'(rv2), 32'd0);

        // Request drop in WAIT abandons it: restart costs two more cycles.
        measure_gnt2(10'h3FD, 10'h000, first);
        chk("req drop gnt cycle", 32'(first), 32'd4);
        to_drive();
        idle_inputs(); rst = 1'b0;
        @(negedge clk);
        chk("req drop rvalid", 32'(rv2), 32'd1);

        // Reset in WAIT abandons the request.
        measure_gnt2(10'h3FF, 10'h002, first);
        chk("rst in wait gnt cycle", 32'(first), 32'd4);
        to_drive();
        idle_inputs(); rst = 1'b0;
        @(negedge clk);

        // ---------------- store granted, reset next cycle ----------------
        to_drive();
        idle_inputs();
        req0 = 1'b1; we = 1'b1; be = 4'hF; addr = 32'h40; wdata = 32'h0BADF00D;
        @(negedge clk);
        chk("sr gnt", 32'(gnt0), 32'd1);
        to_drive();
        idle_inputs(); rst = 1'b1;
        @(negedge clk);
        chk("sr rvalid", 32'(rv0), 32'd0);
        chk("sr rdata", rdata0, 32'h0);
        chk("sr log_valid", 32'(lv0), 32'd0);
        chk("sr log_addr", laddr0, 32'h0);
        to_drive();
        rst = 1'b0;
        @(negedge clk);
        chk("sr after rvalid", 32'(rv0), 32'd0);
        chk("sr after log_valid", 32'(lv0), 32'd0);
        dut0_load("sr mem", 32'h40, 32'h0BADF00D);

        // ---------------- log overflow ----------------
        for (int k = 0; k < 9; k++) begin
            to_drive();
            idle_inputs();
            req0 = 1'b1; we = 1'b1; be = 4'hF;
            addr = 32'h100 + 32'(4 * k); wdata = 32'(k);
            @(negedge clk);
            chk($sformatf("ovf st%0d gnt", k), 32'(gnt0), 32'd1);
            chk($sformatf("ovf st%0d flag", k), 32'(ovf0), 32'd0);
        end
        // Push while full with a simultaneous pop.
        to_drive();
        idle_inputs();
        req0 = 1'b1; we = 1'b1; be = 4'hF; addr = 32'h200; wdata = 32'h100;
        log_ready = 1'b1;
        @(negedge clk);
`ifdef GUVM_DMEM_STORE_LOG_EN
        chk("ovf set", 32'(ovf0), 32'd1);
        chk("ovf head addr", laddr0, 32'h100);
        chk("ovf head data", ldata0, 32'h0);
        for (int k = 1; k < 8; k++) begin
            pop_expect($sformatf("ovf e%0d", k), 32'h100 + 32'(4 * k), 32'(k), 4'hF);
        end
        pop_expect("ovf e8", 32'h200, 32'h100, 4'hF);
        to_drive();
        idle_inputs();
        @(negedge clk);
        chk("ovf drained valid", 32'(lv0), 32'd0);
        chk("ovf sticky", 32'(ovf0), 32'd1);
`else
        chk("nolog ovf", 32'(ovf0), 32'd0);
        chk("nolog valid2", 32'(lv0), 32'd0);
`endif
        dut0_load("ovf mem8", 32'h120, 32'h8);
        dut0_load("ovf mem pp", 32'h200, 32'h100);
        to_drive();
        rst = 1'b1;
        to_drive();
        rst = 1'b0;
        @(negedge clk);
        chk("ovf cleared by rst", 32'(ovf0), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
